cpsr_flag_writer: RTL and testbench
===================================

// Module: cpsr_flag_writer
// PURPOSE
//  Producer side of the NZCV condition-flag interface: computes new flags from
//  the execute-stage ALU, buffers them one stage, then commits them to the
//  architectural CPSR. Drives a forwarded flag view so the condition checker
//  always sees the youngest not-yet-committed flag value. Sits between EX and WB.
// PARAMETERS
//  DATA_W    32        ALU result width
//  FLAGS_W   4         flag vector width; bit 0 V, 1 C, 2 Z, 3 N (`V_i/`C_i/`Z_i/`N_i)
//  RESET_FL  4'b0000   CPSR flag value after reset
// PORTS
//  clk           in   1          rising-edge clock
//  rstn          in   1          asynchronous, active-low reset
//  validin       in   1          EX holds a real instruction this cycle
//  setflagsin    in   1          instruction S bit
//  condpassin    in   1          condition check result for the EX instruction
//  opclassin     in   2          00 logical, 01 arith, 10 multiply, 11 no-flag
//  resultin      in   DATA_W     ALU result
//  alucarryin    in   1          adder carry-out
//  aluoverin     in   1          adder signed overflow
//  shiftcarryin  in   1          barrel-shifter carry-out
//  msrwein       in   1          MSR flag write (direct)
//  msrdatain     in   FLAGS_W    MSR flag value
//  stallin       in   1          pipeline stall: hold both stages
//  flushin       in   1          kill the pending (uncommitted) stage
//  cpsrout       out  FLAGS_W    committed architectural flags
//  cpsrfwdout    out  FLAGS_W    forwarded flags for the condition checker
//  pendingout    out  1          pending stage holds an uncommitted update
// BEHAVIOUR
//  Reset (rstn=0, async): cpsrout=RESET_FL, pending stage cleared,
//   pendingout=0, cpsrfwdout=RESET_FL. Takes effect immediately, mid-op too.
//  Update qualifier upd = validin & condpassin & ((setflagsin & opclassin!=11) | msrwein).
//  Base for next-flag computation = cpsrfwdout (youngest value, not cpsrout).
//  Next flags (nf), opclass:
//   00 logical: N=resultin[DATA_W-1], Z=(resultin==0), C=shiftcarryin, V=base.V
//   01 arith:   N, Z as above, C=alucarryin, V=aluoverin
//   10 mult:    N, Z as above, C=base.C, V=base.V
//   msrwein=1 overrides: nf=msrdatain regardless of opclass/setflags.
//  Stage 1 (pending), per rising edge when stallin=0:
//   flushin=1 -> pending cleared (pendingout=0); flush beats new update.
//   else upd=1 -> pending<=nf, pendingout<=1.
//   else pendingout<=0.
//  Stage 2 (commit): when stallin=0 and pendingout=1 (and not flushed this
//   cycle), cpsrout<=pending value. Latency: flags visible on cpsrfwdout
//   1 cycle after the EX cycle, on cpsrout 2 cycles after.
//  Flush kills only the pending stage; a value being committed in the same
//   edge is the OLD pending value and is lost (flush is for younger wrong-path).
//  stallin=1: both stages and cpsrout hold; flushin ignored while stalled.
//  cpsrfwdout = pendingout ? pending : cpsrout (combinational).
//  Back-to-back updates: second uses first's pending value as base (V/C carry
//   through for logical/mult correctly).
//  No internal wrap/overflow state; all fields bit-exact.
// TESTING
//  1 Reset: rstn=0 mid-stream -> cpsrout=0000, pendingout=0 asynchronously.
//  2 ADDS 0x7FFFFFFF+1: resultin=0x80000000, carry=0, over=1, arith, S=1 ->
//    cycle+1 cpsrfwdout=1001 (N,V), cycle+2 cpsrout=1001.
//  3 ANDS result 0 after test 2, shiftcarry=1 -> nf=0110 (Z,C, V=0 from base? no:
//    base V=1) -> expect 0111; back-to-back forwarding path exercised.
//  4 S=1 but condpassin=0, or opclass=11 -> no change, pendingout=0.
//  5 MSR msrdatain=1010 with flushin=1 same edge -> pending cleared, cpsrout unchanged;
//    repeat without flush -> cpsrout=1010 two cycles later.
//  6 stallin held 3 cycles with pending set -> cpsrout, cpsrfwdout frozen; commit on release.

Source files
------------

// File: rtl/cpsr_flag_writer_if.sv
// NZCV flag-writer bundle: EX-stage inputs plus committed/forwarded flag outputs.
// master = EX/control side driving the ALU/MSR/stall/flush fields; slave = flag writer.
// Ports: validin, setflagsin, condpassin, opclassin, resultin, alucarryin, aluoverin,
//        shiftcarryin, msrwein, msrdatain, stallin, flushin -> cpsrout, cpsrfwdout, pendingout.
interface cpsr_flag_writer_if #(
  parameter int DATA_W  = 32,
  parameter int FLAGS_W = 4
);
  logic               validin;
  logic               setflagsin;
  logic               condpassin;
  logic [1:0]         opclassin;
  logic [DATA_W-1:0]  resultin;
  logic               alucarryin;
  logic               aluoverin;
  logic               shiftcarryin;
  logic               msrwein;
  logic [FLAGS_W-1:0] msrdatain;
  logic               stallin;
  logic               flushin;
  logic [FLAGS_W-1:0] cpsrout;
  logic [FLAGS_W-1:0] cpsrfwdout;
  logic               pendingout;

  modport master (
    output validin, setflagsin, condpassin, opclassin, resultin,
           alucarryin, aluoverin, shiftcarryin, msrwein, msrdatain,
           stallin, flushin,
    input  cpsrout, cpsrfwdout, pendingout
  );

  modport slave (
    input  validin, setflagsin, condpassin, opclassin, resultin,
           alucarryin, aluoverin, shiftcarryin, msrwein, msrdatain,
           stallin, flushin,
    output cpsrout, cpsrfwdout, pendingout
  );
endinterface

// File: rtl/cpsr_flag_writer.sv
// Computes NZCV from the EX-stage ALU, holds it one pending stage, then commits to CPSR.
// Latency: cpsrfwdout shows new flags 1 cycle after EX, cpsrout 2 cycles after.
// Backpressure: stallin freezes both stages (flush ignored); flushin drops the pending stage.
// Ports: clk, rstn (async active-low), fw (cpsr_flag_writer_if.slave bundle).
module cpsr_flag_writer #(
  parameter int                DATA_W   = 32,
  parameter int                FLAGS_W  = 4,
  parameter logic [FLAGS_W-1:0] RESET_FL = '0
) (
  input  logic               clk,
  input  logic               rstn,
  cpsr_flag_writer_if.slave  fw
);

  // Flag bit positions within the NZCV vector.
  localparam int V_I = 0;
  localparam int C_I = 1;
  localparam int Z_I = 2;
  localparam int N_I = 3;

  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ARITH = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;

  logic [FLAGS_W-1:0] cpsr_q,    cpsr_d;
  logic [FLAGS_W-1:0] pend_q,    pend_d;
  logic               pend_vld_q, pend_vld_d;

  logic [FLAGS_W-1:0] fwd;
  logic [FLAGS_W-1:0] nf;
  logic               upd;
  logic               res_zero;

  // Youngest flag value: an uncommitted pending update shadows the CPSR.
  assign fwd = pend_vld_q ? pend_q : cpsr_q;

  assign res_zero = (fw.resultin == '0);

  assign upd = fw.validin & fw.condpassin &
               ((fw.setflagsin & (fw.opclassin != 2'b11)) | fw.msrwein);

  // Next flags are built on the forwarded value so back-to-back updates
  // inherit C/V from the still-pending producer, not the stale CPSR.
  always_comb begin
    nf = fwd;
    if (fw.msrwein) begin
      nf = fw.msrdatain;
    end else begin
      case (fw.opclassin)
        OP_LOGIC: begin
          nf[N_I] = fw.resultin[DATA_W-1];
          nf[Z_I] = res_zero;
          nf[C_I] = fw.shiftcarryin;
        end
        OP_ARITH: begin
          nf[N_I] = fw.resultin[DATA_W-1];
          nf[Z_I] = res_zero;
          nf[C_I] = fw.alucarryin;
          nf[V_I] = fw.aluoverin;
        end
        OP_MULT: begin
          nf[N_I] = fw.resultin[DATA_W-1];
          nf[Z_I] = res_zero;
        end
        default: nf = fwd;
      endcase
    end
  end

  always_comb begin
    cpsr_d     = cpsr_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (!fw.stallin) begin
      // A flush also discards the value that would have committed this edge.
      if (pend_vld_q && !fw.flushin) begin
        cpsr_d = pend_q;
      end
      if (fw.flushin) begin
        pend_vld_d = 1'b0;
      end else if (upd) begin
        pend_d     = nf;
        pend_vld_d = 1'b1;
      end else begin
        pend_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpsr_q     <= RESET_FL;
      pend_q     <= RESET_FL;
      pend_vld_q <= 1'b0;
    end else begin
      cpsr_q     <= cpsr_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign fw.cpsrout    = cpsr_q;
  assign fw.cpsrfwdout = fwd;
  assign fw.pendingout = pend_vld_q;

endmodule

// File: tb/tb_cpsr_flag_writer.sv
// Directed bench for cpsr_flag_writer: hand-computed NZCV after each step.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Ports driven through a cpsr_flag_writer_if instance.
module tb_cpsr_flag_writer;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  cpsr_flag_writer_if #(.DATA_W(32), .FLAGS_W(4)) fw ();

  cpsr_flag_writer #(.DATA_W(32), .FLAGS_W(4), .RESET_FL(4'b0000)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fw   (fw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks committed, forwarded and pending outputs together.
  task automatic chk3(input string tag, input logic [3:0] c, input logic [3:0] f, input logic p);
    chk({tag, ".cpsr"}, fw.cpsrout, c);
    chk({tag, ".fwd"},  fw.cpsrfwdout, f);
    chk({tag, ".pend"}, {3'b000, fw.pendingout}, {3'b000, p});
  endtask

  task automatic idle();
    fw.validin      = 1'b0;
    fw.setflagsin   = 1'b0;
    fw.condpassin   = 1'b0;
    fw.opclassin    = 2'b11;
    fw.resultin     = 32'h0;
    fw.alucarryin   = 1'b0;
    fw.aluoverin    = 1'b0;
    fw.shiftcarryin = 1'b0;
    fw.msrwein      = 1'b0;
    fw.msrdatain    = 4'b0000;
    fw.stallin      = 1'b0;
    fw.flushin      = 1'b0;
  endtask

  // Flag-setting ALU op (S=1, condition passed).
  task automatic alu_op(input logic [1:0] op, input logic [31:0] res,
                        input logic ac, input logic ao, input logic sc);
    idle();
    fw.validin      = 1'b1;
    fw.setflagsin   = 1'b1;
    fw.condpassin   = 1'b1;
    fw.opclassin    = op;
    fw.resultin     = res;
    fw.alucarryin   = ac;
    fw.aluoverin    = ao;
    fw.shiftcarryin = sc;
  endtask

  task automatic msr_op(input logic [3:0] d);
    idle();
    fw.validin    = 1'b1;
    fw.condpassin = 1'b1;
    fw.msrwein    = 1'b1;
    fw.msrdatain  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rstn = 1'b0;
    #2;
    chk3("reset", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk3("post_reset_idle", 4'b0000, 4'b0000, 1'b0);

    // ADDS 0x7FFFFFFF+1 -> N,V
    alu_op(2'b01, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk3("adds_c1", 4'b0000, 4'b1001, 1'b1);
    // ANDS result 0, shifter carry 1, V carried from pending ADDS -> 0111
    alu_op(2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk3("ands_c1", 4'b1001, 4'b0111, 1'b1);
    idle();
    tick();
    chk3("ands_c2", 4'b0111, 4'b0111, 1'b0);

    // Condition failed: no update
    alu_op(2'b01, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    fw.condpassin = 1'b0;
    tick();
    chk3("condfail", 4'b0111, 4'b0111, 1'b0);
    // No-flag opclass with S=1: no update
    alu_op(2'b11, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    tick();
    chk3("op11", 4'b0111, 4'b0111, 1'b0);

    // MSR with flush on the same edge: discarded
    msr_op(4'b1010);
    fw.flushin = 1'b1;
    tick();
    chk3("msr_flush", 4'b0111, 4'b0111, 1'b0);
    msr_op(4'b1010);
    tick();
    chk3("msr_c1", 4'b0111, 4'b1010, 1'b1);
    idle();
    tick();
    chk3("msr_c2", 4'b1010, 4'b1010, 1'b0);

    // Flush while a value is pending: pending value is lost, never committed
    alu_op(2'b01, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk3("pend_before_flush", 4'b1010, 4'b0110, 1'b1);
    idle();
    fw.flushin = 1'b1;
    tick();
    chk3("flush_lost", 4'b1010, 4'b1010, 1'b0);

    // Logical on base 1010: N=1,Z=0,C=0,V=0 -> 1000; then stall 3 cycles
    alu_op(2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("pre_stall", 4'b1010, 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      msr_op(4'b0101);
      fw.stallin = 1'b1;
      fw.flushin = (i == 1);
      tick();
      chk3($sformatf("stall%0d", i), 4'b1010, 4'b1000, 1'b1);
    end
    idle();
    tick();
    chk3("stall_release", 4'b1000, 4'b1000, 1'b0);

    // Multiply: C,V from base. MSR 0011 then MUL result negative -> 1011
    msr_op(4'b0011);
    tick();
    alu_op(2'b10, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("mul_b2b", 4'b0011, 4'b1011, 1'b1);
    alu_op(2'b10, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk3("mul_zero", 4'b1011, 4'b0111, 1'b1);

    // Asynchronous reset mid-operation
    alu_op(2'b01, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk3("async_reset", 4'b0000, 4'b0000, 1'b0);
    idle();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk3("after_async_reset", 4'b0000, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
